// File: rtl/fp_pkg.sv
// Shared single-precision field layout, constants and FSM states for the FP units.
package fp_pkg;

   localparam int EXP_W    = 8;
   localparam int MAN_W    = 23;
   localparam int BIAS     = 127;

   localparam int SIGN_BIT = 31;
   localparam int EXP_MSB  = 30;
   localparam int EXP_LSB  = 23;

   localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
   localparam logic [30:0] FP_INF_MAG  = 31'h7F80_0000;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ALIGN = 3'd1,
      S_ADD   = 3'd2,
      S_NORM  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // 24-bit significand with hidden bit; a zero exponent flushes the whole value to zero
   function automatic logic [MAN_W:0] full_man(input logic [31:0] x);
      if (x[EXP_MSB:EXP_LSB] == '0)
         return '0;
      else
         return {1'b1, x[MAN_W-1:0]};
   endfunction

endpackage

// File: rtl/fp_align.sv
// Operand alignment: orders two operands by magnitude and right-shifts the smaller
// significand to the larger exponent (truncating, no guard/sticky bits).
module fp_align
   import fp_pkg::*;
(
   input  logic [31:0]      op_a,
   input  logic [31:0]      op_b,
   output logic             big_sign,
   output logic             small_sign,
   output logic [EXP_W-1:0] big_exp,
   output logic [MAN_W:0]   big_man,
   output logic [MAN_W:0]   small_man_aligned
);

   logic [EXP_W-1:0] a_exp, b_exp, small_exp, exp_diff;
   logic [MAN_W:0]   a_man, b_man, small_man;
   logic             a_is_big;

   // Magnitude compare (exponent first, significand on a tie), swap, then align
   always_comb begin
      a_exp     = op_a[EXP_MSB:EXP_LSB];
      b_exp     = op_b[EXP_MSB:EXP_LSB];
      a_man     = full_man(op_a);
      b_man     = full_man(op_b);
      a_is_big  = (a_exp > b_exp) || ((a_exp == b_exp) && (a_man >= b_man));

      big_sign   = a_is_big ? op_a[SIGN_BIT] : op_b[SIGN_BIT];
      small_sign = a_is_big ? op_b[SIGN_BIT] : op_a[SIGN_BIT];
      big_exp    = a_is_big ? a_exp : b_exp;
      big_man    = a_is_big ? a_man : b_man;
      small_exp  = a_is_big ? b_exp : a_exp;
      small_man  = a_is_big ? b_man : a_man;

      exp_diff   = big_exp - small_exp;
      if (exp_diff >= EXP_W'(MAN_W + 1))
         small_man_aligned = '0;
      else
         small_man_aligned = small_man >> exp_diff;
   end

endmodule

// File: rtl/fp_sub_seq.sv
// Multicycle single-precision subtractor (result = a - b) with start/done handshake.
// b's sign is flipped on capture, after which the datapath is a signed-magnitude adder
// that normalizes one bit per cycle, so latency depends on the operands.
module fp_sub_seq
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   state_t state, state_nx;

   logic [31:0]      op_a, op_b;

   logic             al_big_sign, al_small_sign;
   logic [EXP_W-1:0] al_big_exp;
   logic [MAN_W:0]   al_big_man, al_small_man;

   logic             big_sign_r, small_sign_r;
   logic [EXP_W-1:0] big_exp_r;
   logic [MAN_W:0]   big_man_r, small_man_r;

   logic [MAN_W+1:0] sum_r;
   logic [EXP_W-1:0] exp_r;
   logic             sign_r;
   logic [31:0]      result_r;

   logic             norm_finish;
   logic [31:0]      norm_result;
   logic [EXP_W:0]   exp_inc;

   fp_align u_align (
      .op_a              (op_a),
      .op_b              (op_b),
      .big_sign          (al_big_sign),
      .small_sign        (al_small_sign),
      .big_exp           (al_big_exp),
      .big_man           (al_big_man),
      .small_man_aligned (al_small_man)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nx;
   end

   // Normalization decision for the current sum and next-state selection
   always_comb begin
      state_nx    = state;
      norm_finish = 1'b0;
      norm_result = FP_POS_ZERO;
      exp_inc     = {1'b0, exp_r} + 1'b1;

      if (sum_r[MAN_W+1]) begin
         // carry out: one right shift; an exponent of 255 or more saturates to infinity
         norm_finish = 1'b1;
         if (exp_inc >= (EXP_W+1)'(255))
            norm_result = {sign_r, FP_INF_MAG};
         else
            norm_result = {sign_r, exp_inc[EXP_W-1:0], sum_r[MAN_W:1]};
      end else if (sum_r == '0) begin
         // exact cancellation is always +0
         norm_finish = 1'b1;
         norm_result = FP_POS_ZERO;
      end else if (sum_r[MAN_W]) begin
         norm_finish = 1'b1;
         norm_result = {sign_r, exp_r, sum_r[MAN_W-1:0]};
      end else if (exp_r <= EXP_W'(1)) begin
         // a left shift would take the exponent to zero: flush to +0
         norm_finish = 1'b1;
         norm_result = FP_POS_ZERO;
      end

      case (state)
         S_IDLE:  if (start) state_nx = S_ALIGN;
         S_ALIGN: state_nx = S_ADD;
         S_ADD:   state_nx = S_NORM;
         S_NORM:  if (norm_finish) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Datapath registers: capture, align, add, and one-bit-per-cycle normalize
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_a         <= '0;
         op_b         <= '0;
         big_sign_r   <= 1'b0;
         small_sign_r <= 1'b0;
         big_exp_r    <= '0;
         big_man_r    <= '0;
         small_man_r  <= '0;
         sum_r        <= '0;
         exp_r        <= '0;
         sign_r       <= 1'b0;
         result_r     <= FP_POS_ZERO;
      end else begin
         case (state)
            // capture stage: subtrahend sign inverted here
            S_IDLE: begin
               if (start) begin
                  op_a <= a;
                  op_b <= {~b[SIGN_BIT], b[SIGN_BIT-1:0]};
               end
            end
            // align stage
            S_ALIGN: begin
               big_sign_r   <= al_big_sign;
               small_sign_r <= al_small_sign;
               big_exp_r    <= al_big_exp;
               big_man_r    <= al_big_man;
               small_man_r  <= al_small_man;
            end
            // add stage: larger minus smaller never goes negative
            S_ADD: begin
               if (big_sign_r == small_sign_r)
                  sum_r <= {1'b0, big_man_r} + {1'b0, small_man_r};
               else
                  sum_r <= {1'b0, big_man_r} - {1'b0, small_man_r};
               exp_r  <= big_exp_r;
               sign_r <= big_sign_r;
            end
            // normalize stage: result loaded on the way into DONE
            S_NORM: begin
               if (norm_finish) begin
                  result_r <= norm_result;
               end else begin
                  sum_r <= {sum_r[MAN_W:0], 1'b0};
                  exp_r <= exp_r - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy   = (state != S_IDLE);
   assign done   = (state == S_DONE);
   assign result = result_r;

endmodule

// File: tb/tb_fp_sub_seq.sv
// Self-checking bench for fp_sub_seq: directed vector table, handshake/reset corner
// sequences, and randomized operands against an arithmetic reference model.
module tb_fp_sub_seq;
   import fp_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      int          lat;
      string       name;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   fp_sub_seq dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   // Reference: aligns to the larger exponent with truncation, adds as signed integers,
   // then places the leading one at bit 23 with plain arithmetic.
   function automatic void ref_sub(input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] r, output int lat);
      longint mx, my, big_m, sm_m, total, mag;
      int     ex, ey, big_e, sm_e, d, p, k, e;
      logic   sx, sy, big_s, sm_s, neg;
      sx = x[31];
      sy = ~y[31];
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      mx = (ex == 0) ? 0 : longint'(x[22:0]) + 64'd8388608;
      my = (ey == 0) ? 0 : longint'(y[22:0]) + 64'd8388608;
      if ((longint'(ex) * 64'd16777216 + mx) >= (longint'(ey) * 64'd16777216 + my)) begin
         big_s = sx; big_e = ex; big_m = mx; sm_s = sy; sm_e = ey; sm_m = my;
      end else begin
         big_s = sy; big_e = ey; big_m = my; sm_s = sx; sm_e = ex; sm_m = mx;
      end
      d = big_e - sm_e;
      sm_m = (d >= 24) ? 0 : (sm_m >> d);
      total = (big_s ? -big_m : big_m) + (sm_s ? -sm_m : sm_m);
      neg = (total < 0);
      mag = neg ? -total : total;
      lat = 3;
      r = 32'h0;
      if (mag == 0) return;
      p = 0;
      for (int i = 0; i <= 24; i++)
         if (((mag >> i) & 1) != 0) p = i;
      if (p == 24) begin
         e = big_e + 1;
         if (e >= 255) r = {neg, 8'hFF, 23'h0};
         else          r = {neg, 8'(e), 23'(mag >> 1)};
      end else if (p == 23) begin
         r = {neg, 8'(big_e), 23'(mag)};
      end else begin
         k = 23 - p;
         if (big_e - k >= 1) begin
            r   = {neg, 8'(big_e - k), 23'(mag << k)};
            lat = 3 + k;
         end else begin
            r   = 32'h0;
            lat = 3 + (big_e - 1);
         end
      end
   endfunction

   // One transaction: start pulsed across an edge, then wait (bounded) for done.
   task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                         output logic [31:0] res, output int lat,
                         output bit busy_ok, output bit done_ok);
      @(negedge clk);
      a = op_a;
      b = op_b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      busy_ok = busy;
      done_ok = 1'b0;
      lat = -1;
      res = 32'hDEAD_BEEF;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         if (!busy) busy_ok = 1'b0;
         if (done) begin
            lat = e;
            break;
         end
      end
      res = result;
      @(posedge clk);
      #1;
      done_ok = !done && !busy;
   endtask

   function automatic void add_vec(input logic [31:0] va, input logic [31:0] vb,
                                   input logic [31:0] vr, input int vl, input string nm);
      vec_t v;
      v.a = va; v.b = vb; v.r = vr; v.lat = vl; v.name = nm;
      tbl.push_back(v);
   endfunction

   initial begin
      logic [31:0] res, ra, rb, rr, rnd;
      logic [7:0]  e8;
      int          lat, rl, mode;
      bit          bok, dok, seen_done;

      reset = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;

      add_vec(32'h40400000, 32'h3F800000, 32'h40000000,  3, "3.0-1.0");
      add_vec(32'h3F800000, 32'h40400000, 32'hC0000000,  3, "1.0-3.0");
      add_vec(32'h3FC00000, 32'h3FC00000, 32'h00000000,  3, "x-x");
      add_vec(32'h3F800000, 32'hBF800000, 32'h40000000,  3, "carry");
      add_vec(32'h7F7FFFFF, 32'hFF7FFFFF, 32'h7F800000,  3, "overflow");
      add_vec(32'h3F800000, 32'h3F7FFFFF, 32'h34000000, 26, "n23");
      add_vec(32'h3F800000, 32'h3F000000, 32'h3F000000,  4, "n1");
      add_vec(32'h00000000, 32'h3F800000, 32'hBF800000,  3, "0-1.0");
      add_vec(32'h80000000, 32'h80000000, 32'h00000000,  3, "neg0-neg0");
      add_vec(32'h00C00000, 32'h00800000, 32'h00000000,  3, "underflow");
      add_vec(32'h7F800000, 32'h3F800000, 32'h7F800000,  3, "exp255 ordinary");
      add_vec(32'hFF800000, 32'h7F800000, 32'hFF800000,  3, "neg overflow");
      add_vec({1'b0, 8'(BIAS), 23'h0}, 32'h00400000, 32'h3F800000, 3, "denorm flushed");

      #12;
      check("reset busy",   32'(busy),   32'h0);
      check("reset done",   32'(done),   32'h0);
      check("reset result", result,      32'h0);
      @(negedge clk);
      reset = 1'b0;

      foreach (tbl[i]) begin
         run_op(tbl[i].a, tbl[i].b, res, lat, bok, dok);
         check({tbl[i].name, " result"},  res,        tbl[i].r);
         check({tbl[i].name, " latency"}, 32'(lat),   32'(tbl[i].lat));
         check({tbl[i].name, " busy"},    32'(bok),   32'h1);
         check({tbl[i].name, " done1"},   32'(dok),   32'h1);
      end

      // start held high while busy with other operands must be ignored
      @(negedge clk);
      a = 32'h40400000;
      b = 32'h3F800000;
      start = 1'b1;
      @(posedge clk);
      #1;
      a = 32'h3F800000;
      b = 32'h3F7FFFFF;
      lat = -1;
      for (int e = 1; e <= 40; e++) begin
         @(posedge clk);
         #1;
         if (e == 3) start = 1'b0;
         if (done) begin
            lat = e;
            break;
         end
      end
      start = 1'b0;
      check("ignore-start result",  result,   32'h40000000);
      check("ignore-start latency", 32'(lat), 32'd3);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk);
         #1;
         check($sformatf("hold%0d result", c), result,     32'h40000000);
         check($sformatf("hold%0d done", c),   32'(done),  32'h0);
         check($sformatf("hold%0d busy", c),   32'(busy),  32'h0);
      end

      // asynchronous reset in the middle of a long normalization
      @(negedge clk);
      a = 32'h3F800000;
      b = 32'h3F7FFFFF;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("pre-reset busy", 32'(busy), 32'h1);
      #2;
      reset = 1'b1;
      #1;
      check("async reset busy",   32'(busy), 32'h0);
      check("async reset done",   32'(done), 32'h0);
      check("async reset result", result,    32'h0);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      seen_done = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(posedge clk);
         #1;
         if (done) seen_done = 1'b1;
      end
      check("no done after abort", 32'(seen_done), 32'h0);
      run_op(32'h40400000, 32'h3F800000, res, lat, bok, dok);
      check("post-reset result",  res,      32'h40000000);
      check("post-reset latency", 32'(lat), 32'd3);

      // randomized operands against the reference model
      for (int i = 0; i < 300; i++) begin
         ra   = $urandom;
         rnd  = $urandom;
         mode = $urandom_range(0, 4);
         case (mode)
            0: rb = rnd;
            1: rb = {rnd[31], ra[30:23], rnd[22:0]};
            2: begin
               e8 = ra[30:23] + 8'($urandom_range(0, 4)) - 8'd2;
               rb = {rnd[31], e8, rnd[22:0]};
            end
            3: rb = ra ^ {9'h0, 23'($urandom_range(0, 1023))};
            default: begin
               ra[30:23] = 8'($urandom_range(1, 3));
               rb = ra ^ {8'h0, 24'($urandom_range(0, 65535))};
            end
         endcase
         ref_sub(ra, rb, rr, rl);
         run_op(ra, rb, res, lat, bok, dok);
         check($sformatf("rnd%0d %h-%h result", i, ra, rb),  res,      rr);
         check($sformatf("rnd%0d %h-%h latency", i, ra, rb), 32'(lat), 32'(rl));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
